window_3x3_feeder: RTL
======================

// Module: window_3x3_feeder
// PURPOSE
//  Upstream stage of the neuron: accepts a raster-order pixel stream and buffers two image lines.
//  Builds each valid 3x3 window (no padding), presents it as the neuron's 9-element input bus,
//  pulses start_ and stalls the stream until the neuron's end_ reports completion.
//  One frame yields (IMG_W-2)*(IMG_H-2) windows; frame_done marks the last one retired.
// PARAMETERS
//  IMG_W  8  pixels per line; legal range >= 3
//  IMG_H  8  lines per frame; legal range >= 3
//  PIX_W  9  bits per pixel; matches the neuron's per-input width
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous active-high reset
//  pix_valid   in   1          upstream pixel valid
//  pix_data    in   PIX_W      pixel value, unsigned
//  pix_ready   out  1          feeder can accept a pixel this cycle
//  win_data    out  [8:0][PIX_W-1:0]  window to neuron inputs; [0]=top-left .. [8]=bottom-right, row-major
//  start_      out  1          one-cycle pulse that launches the neuron on win_data
//  neur_end_   in   1          neuron end_ (level; held high after completion until next start)
//  frame_done  out  1          one-cycle pulse after the frame's final window is retired
// BEHAVIOUR
//  Reset (async, while rst=1): state=FILL, col=row=0, start_=0, frame_done=0, pix_ready=0,
//   win_data=0, end-edge register=0. Line-buffer RAM is not cleared. pix_ready=1 from the first
//   clk edge after rst falls. Reset mid-window aborts it; no start_/frame_done is emitted for it.
//  Accept: pixel taken on posedge clk when pix_valid && pix_ready. pix_data is ignored otherwise.
//  Counters: col increments per accept and wraps IMG_W-1 -> 0 with row+1.
//   row wraps IMG_H-1 -> 0. Both update on the accepting edge.
//  Line buffers: two IMG_W x PIX_W lines plus a 3x3 shift array. Each accept shifts the column in.
//   Taps: lines row-2, row-1 and the current pixel.
//  Window valid: the accepted pixel has row>=2 && col>=2 (pre-increment coordinates).
//   On that edge, register win_data = pixels (row-2..row, col-2..col) and go to ISSUE.
//  FSM states:
//   FILL       pix_ready=1; valid window -> ISSUE; otherwise stay.
//   ISSUE      pix_ready=0, start_=1 for exactly this cycle -> WAIT_DONE.
//   WAIT_DONE  pix_ready=0; wait for a rising edge of neur_end_ (neur_end_ && !neur_end_q).
//              On the edge: if the window was the frame's last pixel (IMG_H-1, IMG_W-1) -> FRAME_END,
//              else -> FILL.
//              A level already high at entry is NOT completion; the neuron clears end_ first.
//   FRAME_END  frame_done=1 for one cycle, pix_ready=0 -> FILL (counters already wrapped to 0,0).
//  Latency: window-completing accept edge -> start_ high in the next cycle.
//   neur_end_ rising edge sampled at edge k -> pix_ready=1 in cycle k+1, or frame_done=1 in that cycle.
//  win_data is held stable from ISSUE until leaving WAIT_DONE and changes only on a window accept.
//  neur_end_ edges in FILL or FRAME_END are ignored; the edge register updates every cycle.
//  Pixels at col<2 or row<2 fill buffers only and never stall. There is no wrap-around window
//   across line ends.
//  pix_valid may toggle freely; no pixel is lost or duplicated under any pix_valid pattern.
// TESTING
//  T1 8x8 ramp pixel=r*8+c, neuron model end_ 11 cycles after start_ -> first start_ after pixel 18;
//     win_data={0,1,2,8,9,10,16,17,18}.
//  T2 Same run -> exactly 36 start_ pulses. frame_done pulses once, 1 cycle after the 36th end_ rise.
//     Window for pixel (3,2) = {8,9,10,16,17,18,24,25,26}.
//  T3 neur_end_ held high 3 cycles after start_, then low 2, then high -> release only on the final rise.
//     pix_ready stays 0 throughout.
//  T4 pix_valid random 50% duty and also held constantly high -> window sequence identical to T1/T2.
//     No accept while pix_ready=0.
//  T5 rst pulsed during WAIT_DONE of window 5 -> outputs zero immediately. pix_ready=1 after release.
//     The next start_ only after pixel (2,2) of a fresh frame.
//  T6 Two back-to-back frames, 2nd ramp offset +100 -> 2nd frame's first window
//     ={100,101,102,108,109,110,116,117,118}. Two frame_done pulses total.

Source files
------------

// File: rtl/window_3x3_feeder.sv
// 3x3 sliding-window feeder: keeps two image lines, hands each complete window to the neuron
// and holds the pixel stream off until the neuron reports completion.
module window_3x3_feeder #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int PIX_W = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   input  logic [PIX_W-1:0]      pix_data,
   output logic                  pix_ready,
   output logic [8:0][PIX_W-1:0] win_data,
   output logic                  start_,
   input  logic                  neur_end_,
   output logic                  frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      FRAME_END = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic             run_q;
   logic             end_q;
   logic             last_q;
   logic             accept;
   logic             win_ok;
   logic             last_pix;
   logic             end_rise;
   logic [PIX_W-1:0] tap_top;
   logic [PIX_W-1:0] tap_mid;

   // line2 holds row-2, line1 holds row-1; prev_* hold columns col-2 ([0]) and col-1 ([1])
   logic [PIX_W-1:0] line1 [IMG_W];
   logic [PIX_W-1:0] line2 [IMG_W];
   logic [PIX_W-1:0] prev_top [2];
   logic [PIX_W-1:0] prev_mid [2];
   logic [PIX_W-1:0] prev_bot [2];

   assign tap_top  = line2[col];
   assign tap_mid  = line1[col];
   assign accept   = pix_valid && pix_ready;
   assign win_ok   = accept && (row >= RW'(2)) && (col >= CW'(2));
   assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign end_rise = neur_end_ && !end_q;

   // Pixel storage is never reset; stale contents are overwritten before any window uses them.
   always_ff @(posedge clk) begin
      if (accept) begin
         line2[col]  <= tap_mid;
         line1[col]  <= pix_data;
         prev_top[0] <= prev_top[1];
         prev_mid[0] <= prev_mid[1];
         prev_bot[0] <= prev_bot[1];
         prev_top[1] <= tap_top;
         prev_mid[1] <= tap_mid;
         prev_bot[1] <= pix_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FILL;
         col      <= '0;
         row      <= '0;
         run_q    <= 1'b0;
         end_q    <= 1'b0;
         last_q   <= 1'b0;
         win_data <= '0;
      end else begin
         state <= state_nxt;
         run_q <= 1'b1;
         end_q <= neur_end_;
         if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (win_ok) begin
            win_data[0] <= prev_top[0];
            win_data[1] <= prev_top[1];
            win_data[2] <= tap_top;
            win_data[3] <= prev_mid[0];
            win_data[4] <= prev_mid[1];
            win_data[5] <= tap_mid;
            win_data[6] <= prev_bot[0];
            win_data[7] <= prev_bot[1];
            win_data[8] <= pix_data;
            last_q      <= last_pix;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:      if (win_ok) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: if (end_rise) state_nxt = last_q ? FRAME_END : FILL;
         FRAME_END: state_nxt = FILL;
         default:   state_nxt = FILL;
      endcase
   end

   // run_q keeps pix_ready low until the first edge after reset is released
   always_comb begin
      pix_ready  = 1'b0;
      start_     = 1'b0;
      frame_done = 1'b0;
      case (state)
         FILL:      pix_ready  = run_q;
         ISSUE:     start_     = 1'b1;
         FRAME_END: frame_done = 1'b1;
         default:   ;
      endcase
   end

endmodule
